// File: rtl/perf_cntr_bank.sv
// Bank of per-core performance counters behind a word-addressed CSR port.
// Each counter can clear, count cycles, count event strobes or hold; SNAP gives coherent multi-word reads.
module perf_cntr_bank #(
    parameter int NUM_CNTRS = 4,
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           addr_i,
    input  logic [31:0]          wdata_i,
    input  logic                 w_en_i,
    input  logic [NUM_CNTRS-1:0] event_i,
    output logic [31:0]          rdata_o,
    output logic                 irq_o
);

    localparam int         HI_W       = CNT_WIDTH - 32;
    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_SNAP   = 6'd1;
    localparam logic [5:0] IDX_OVF    = 6'd2;
    localparam logic [5:0] IDX_OVF_EN = 6'd3;

    typedef enum logic [1:0] {
        MODE_CLEAR = 2'b00,
        MODE_CYCLE = 2'b01,
        MODE_EVENT = 2'b10,
        MODE_HOLD  = 2'b11
    } cnt_mode_e;

    logic [NUM_CNTRS-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [NUM_CNTRS-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NUM_CNTRS-1:0][CNT_WIDTH-1:0] shadow_q;
    logic [NUM_CNTRS-1:0][CNT_WIDTH-1:0] shadow_d;
    logic [2*NUM_CNTRS-1:0]              ctrl_q;
    logic [2*NUM_CNTRS-1:0]              ctrl_d;
    logic [NUM_CNTRS-1:0]                ovf_q;
    logic [NUM_CNTRS-1:0]                ovf_d;
    logic [NUM_CNTRS-1:0]                ovf_en_q;
    logic [NUM_CNTRS-1:0]                ovf_en_d;
    logic [31:0]                         rdata_q;
    logic [31:0]                         rdata_d;

    logic [NUM_CNTRS-1:0] cnt_inc;
    logic [NUM_CNTRS-1:0] cnt_wrap;
    logic [5:0]           word_idx;
    logic                 wr_ctrl;
    logic                 wr_snap;
    logic                 wr_ovf;
    logic                 wr_ovf_en;

    assign word_idx = addr_i[7:2];

    always_comb begin
        wr_ctrl   = w_en_i && (word_idx == IDX_CTRL);
        wr_snap   = w_en_i && (word_idx == IDX_SNAP);
        wr_ovf    = w_en_i && (word_idx == IDX_OVF);
        wr_ovf_en = w_en_i && (word_idx == IDX_OVF_EN);
    end

    // Modes come from ctrl_q, so a CTRL write only affects the following cycle.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_inc  = '0;
        cnt_wrap = '0;
        for (int i = 0; i < NUM_CNTRS; i++) begin
            case (cnt_mode_e'(ctrl_q[2*i +: 2]))
                MODE_CLEAR: cnt_d[i] = '0;
                MODE_CYCLE: cnt_inc[i] = 1'b1;
                MODE_EVENT: cnt_inc[i] = event_i[i];
                default:    cnt_inc[i] = 1'b0;
            endcase
            if (cnt_inc[i]) begin
                cnt_d[i]    = cnt_q[i] + CNT_WIDTH'(1);
                cnt_wrap[i] = &cnt_q[i];
            end
        end
    end

    // Shadows take the pre-increment value present at the SNAP edge.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_snap) begin
            shadow_d = cnt_q;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        ovf_en_d = ovf_en_q;
        ovf_d    = ovf_q;
        if (wr_ctrl) begin
            ctrl_d = wdata_i[2*NUM_CNTRS-1:0];
        end
        if (wr_ovf_en) begin
            ovf_en_d = wdata_i[NUM_CNTRS-1:0];
        end
        if (wr_ovf) begin
            ovf_d = ovf_q & ~wdata_i[NUM_CNTRS-1:0];
        end
        // A fresh wrap beats a same-cycle write-1-to-clear.
        ovf_d = ovf_d | cnt_wrap;
    end

    // Read decode looks only at current register state, so reads see pre-write values.
    always_comb begin
        rdata_d = '0;
        if (word_idx == IDX_CTRL) begin
            rdata_d[2*NUM_CNTRS-1:0] = ctrl_q;
        end else if (word_idx == IDX_OVF) begin
            rdata_d[NUM_CNTRS-1:0] = ovf_q;
        end else if (word_idx == IDX_OVF_EN) begin
            rdata_d[NUM_CNTRS-1:0] = ovf_en_q;
        end else begin
            for (int i = 0; i < NUM_CNTRS; i++) begin
                if (word_idx == 6'(4 + 2*i)) begin
                    rdata_d = shadow_q[i][31:0];
                end
                if (word_idx == 6'(5 + 2*i)) begin
                    rdata_d[HI_W-1:0] = shadow_q[i][CNT_WIDTH-1:32];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            ctrl_q   <= '0;
            ovf_q    <= '0;
            ovf_en_q <= '0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            ovf_en_q <= ovf_en_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign irq_o   = |(ovf_q & ovf_en_q);

endmodule
